inst_fetch_buffer: RTL and testbench
====================================

# inst_fetch_buffer

Instruction fetch stage directly upstream of the control unit. Owns the fetch program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions in a small prefetch FIFO. Instructions are presented to the control unit over a valid/ready interface. The block also accepts jump redirects and a halt request from the control unit.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; must be a power of 2, minimum 2.
- `ADDR_W`, 5: fetch PC width, addressing a 32-word program memory.
- `INST_W`, 32: instruction width.
- `clk` in 1: the single clock; all state is updated on the rising edge.
- `sys_rst` in 1: asynchronous, active-low reset.
- `mem_req` out 1: read request to instruction memory.
- `mem_addr` out ADDR_W: read word address; held stable while `mem_req` is high.
- `mem_ack` in 1: read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in INST_W: read data.
- `inst_valid` out 1: the FIFO head holds an instruction.
- `inst_data` out INST_W: FIFO head instruction.
- `inst_pc` out ADDR_W: address of the FIFO head instruction.
- `inst_ready` in 1: the control unit consumes the head when `inst_valid` and `inst_ready` are both high.
- `redirect` in 1: one-cycle jump pulse.
- `redirect_pc` in ADDR_W: jump target, sampled when `redirect` is high.
- `halt` in 1: level signal; while high, no new fetch is issued.
- `fifo_count` out clog2(DEPTH)+1: current number of FIFO entries.

## Operation
- The FSM has four states: IDLE, REQ, DRAIN, HALTED.
  - IDLE: no request outstanding. A request is issued when `halt`=0 and `fifo_count` < DEPTH; the FSM moves to REQ with `mem_req`=1 and `mem_addr`=fetch_pc.
  - REQ: the FSM waits for `mem_ack`. On ack, it writes {`mem_rdata`, `mem_addr`} to the FIFO and sets fetch_pc = `mem_addr`+1.
    - It issues the next request back-to-back (stays in REQ, `mem_req` remains 1, address+1) if `halt`=0 and the post-update count < DEPTH.
    - Otherwise it returns to IDLE (`halt`=0) or goes to HALTED (`halt`=1).
  - DRAIN: a redirect arrived while a request was outstanding. `mem_req` stays high with the old address until `mem_ack`. The response is discarded, and the FSM then goes to IDLE, issuing to redirect_pc on the following cycle.
  - HALTED: no requests are issued. The FSM returns to IDLE when `halt` falls. FIFO contents remain poppable.
- A request is never abandoned: the stable-address and held-`mem_req` rules apply until ack.
- Redirect:
  - The FIFO is flushed (count goes to 0 and `inst_valid` goes low the next cycle) and fetch_pc = `redirect_pc`.
  - Redirect in the same cycle as `mem_ack`: the ack data is discarded, no DRAIN is entered, and the new request to `redirect_pc` is issued on the next cycle.
  - Redirect in the same cycle as a pop: the pop counts as consumed, and the flush wins for the remaining entries.
  - Redirect while HALTED: the flush and PC update happen, and the FSM stays HALTED.
- FIFO behaviour:
  - A simultaneous write and pop leaves the count unchanged. This is legal even when full, because a write only occurs for a request issued with a reserved slot.
  - A pop while empty is ignored.
  - A write is never allowed to overflow: issue requires `fifo_count` + outstanding < DEPTH.
- PC arithmetic is modulo 2^ADDR_W: address 31 + 1 wraps to 0.

## Timing
- Reset (`sys_rst`=0, async) clears all outputs and state:
  - `mem_req`=0, `mem_addr`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `fifo_count`=0.
  - fetch_pc=0, FSM=IDLE, FIFO pointers=0.
- After reset release:
  - `mem_req` rises at the first rising edge.
  - `mem_ack` may be sampled high in that same cycle.
  - `inst_valid` rises after the edge that captures the ack.
  - Minimum PC-0-to-`inst_valid` latency is 2 edges.
- Fetch latency equals memory wait + 1 cycle. With `mem_ack` tied high and `inst_ready` high, throughput is one instruction per cycle.
- `inst_valid`, `inst_data`, and `inst_pc` are driven from registered FIFO state only, with no combinational path from `mem_ack`.
- After a redirect pulse at edge N:
  - `inst_valid`=0 from N+1.
  - `mem_req`/`mem_addr`=`redirect_pc` from N+1 when no request is outstanding or the ack fell at N; otherwise from the edge after the draining ack.
- Reset asserted mid-request drops `mem_req` immediately (asynchronously). The memory must tolerate the abandoned request.

## Test plan
- Reset release with `mem_ack` tied high and `inst_ready`=1 → addresses 0,1,2,… are issued on consecutive cycles, `inst_pc` follows 0,1,2,… one per cycle, and `inst_data` matches memory.
- `inst_ready`=0 and `mem_ack` high → exactly 4 fetches (addresses 0–3); `mem_req` then drops and `fifo_count`=4. Raising `inst_ready` resumes fetching at address 4 with no loss or duplication.
- Memory with a 3-cycle ack delay, redirect to 20 pulsed one cycle after `mem_req` rises → `mem_addr` is held at the old address until ack and that data is discarded. The next request is to 20, and the first `inst_pc` seen after the flush is 20.
- Redirect to 9 in the same cycle as `mem_ack` for address 5 → address 5 never appears at `inst_pc`, and `mem_addr`=9 on the next cycle.
- Fetch PC at 30 with continuous flow → `inst_pc` sequence is 30, 31, 0, 1.
- `halt`=1 while 2 entries are queued → no new `mem_req`, both entries still pop. Dropping `halt` resumes fetching at the next sequential address. Asserting `sys_rst` mid-stream clears all outputs immediately.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: owns the fetch PC, sequences instruction memory reads
// and queues returned words in a prefetch FIFO for the control unit.
module inst_fetch_buffer #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 5,
  parameter  int INST_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              sys_rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [CNT_W-1:0]  fifo_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    HALTED
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_q, pc_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;

  logic [INST_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt_q, cnt_post;
  logic              push, pop, room;

  assign push     = (state == REQ) && mem_ack && !redirect;
  assign pop      = (cnt_q != '0) && inst_ready;
  assign cnt_post = cnt_q + CNT_W'(push) - CNT_W'(pop);
  assign room     = cnt_post < CNT_W'(DEPTH);

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    addr_nx  = addr_q;
    unique case (state)
      IDLE: begin
        if (redirect) pc_nx = redirect_pc;
        if (!halt && (redirect || cnt_q < CNT_W'(DEPTH))) begin
          state_nx = REQ;
          addr_nx  = redirect ? redirect_pc : pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          pc_nx = redirect_pc;
          if (!mem_ack)  state_nx = DRAIN;
          else if (halt) state_nx = HALTED;
          else           addr_nx  = redirect_pc;
        end else if (mem_ack) begin
          pc_nx = addr_q + 1'b1;
          if (halt)      state_nx = HALTED;
          else if (room) addr_nx  = addr_q + 1'b1;
          else           state_nx = IDLE;
        end
      end
      // outstanding read is completed but its data thrown away
      DRAIN: begin
        if (redirect) pc_nx = redirect_pc;
        if (mem_ack)  state_nx = IDLE;
      end
      HALTED: begin
        if (redirect) pc_nx = redirect_pc;
        if (!halt)    state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state  <= IDLE;
      pc_q   <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_nx;
      pc_q   <= pc_nx;
      addr_q <= addr_nx;
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= wr_ptr;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= mem_rdata;
        tag_q[wr_ptr]  <= addr_q;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_post;
    end
  end

  assign mem_req    = (state == REQ) || (state == DRAIN);
  assign mem_addr   = addr_q;
  assign inst_valid = cnt_q != '0;
  assign inst_data  = data_q[rd_ptr];
  assign inst_pc    = tag_q[rd_ptr];
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: memory responder with variable wait,
// in-order stream reference model, directed and random phases.
module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        mem_req;
  logic [4:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [4:0]  inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [4:0]  redirect_pc = '0;
  logic        halt = 1'b0;
  logic [2:0]  fifo_count;

  logic [31:0] mem [32];
  logic [4:0]  exp_pc = '0;
  logic [4:0]  want [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
  int          delay_min = 0;
  int          delay_max = 0;
  int          vectors = 0;
  int          errors = 0;

  inst_fetch_buffer dut (
    .clk(clk), .sys_rst(sys_rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // memory: each request waits a random number of cycles, then acks
  initial begin
    int  wcnt;
    int  dly;
    bit  busy;
    wcnt = 0; dly = 0; busy = 0;
    forever begin
      @(negedge clk);
      if (!sys_rst || !mem_req) begin
        mem_ack = 1'b0;
        busy = 0;
      end else begin
        if (!busy) begin
          busy = 1;
          wcnt = 0;
          dly = $urandom_range(delay_max, delay_min);
        end
        if (wcnt >= dly) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          busy = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          wcnt++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs are already set; consume per model, then advance one cycle
  task automatic tick();
    logic       p_req, p_ack, p_halt;
    logic [4:0] p_addr;
    p_req = mem_req; p_ack = mem_ack;
    p_halt = halt; p_addr = mem_addr;
    if (inst_valid && inst_ready) begin
      chk("pop_pc", 32'(inst_pc), 32'(exp_pc));
      chk("pop_data", inst_data, mem[exp_pc]);
      exp_pc = exp_pc + 5'd1;
    end
    if (redirect) exp_pc = redirect_pc;
    @(negedge clk); #1;
    if (p_req && !p_ack) begin
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("addr_hold", 32'(mem_addr), 32'(p_addr));
    end
    if (p_halt && !p_req) chk("halt_noreq", 32'(mem_req), 32'd0);
    chk("cnt_max", 32'(fifo_count <= 3'd4), 32'd1);
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    @(negedge clk); #1;
    sys_rst = 1'b1;
    exp_pc = '0;
  endtask

  task automatic set_delay(input int lo, input int hi);
    delay_min = lo;
    delay_max = hi;
  endtask

  initial begin
    int  n;
    int  k;
    int  idx;
    bit  seen5;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    set_delay(0, 0);
    #2;

    // streaming at one per cycle
    inst_ready = 1'b1;
    do_reset();
    tick();
    chk("t1_req", 32'(mem_req), 32'd1);
    chk("t1_addr0", 32'(mem_addr), 32'd0);
    chk("t1_nvalid", 32'(inst_valid), 32'd0);
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("t1_valid", 32'(inst_valid), 32'd1);
      chk("t1_pc", 32'(inst_pc), 32'(j));
      chk("t1_addr", 32'(mem_addr), 32'(j + 1));
    end

    // backpressure fills exactly DEPTH entries
    inst_ready = 1'b0;
    do_reset();
    n = 0;
    for (int j = 0; j < 8; j++) begin
      if (mem_req && mem_ack) n++;
      tick();
    end
    chk("t2_fetches", 32'(n), 32'd4);
    chk("t2_req_low", 32'(mem_req), 32'd0);
    chk("t2_cnt", 32'(fifo_count), 32'd4);
    inst_ready = 1'b1;
    k = 0;
    while (!mem_req && k < 6) begin tick(); k++; end
    chk("t2_resume_req", 32'(mem_req), 32'd1);
    chk("t2_resume_addr", 32'(mem_addr), 32'd4);
    repeat (10) tick();

    // redirect during a slow read drains it
    inst_ready = 1'b0;
    set_delay(3, 3);
    do_reset();
    tick();
    chk("t3_req", 32'(mem_req), 32'd1);
    tick();
    redirect = 1'b1; redirect_pc = 5'd20;
    tick();
    redirect = 1'b0;
    chk("t3_flush", 32'(inst_valid), 32'd0);
    k = 0;
    while (!mem_ack && k < 10) begin
      chk("t3_hold", 32'(mem_addr), 32'd0);
      tick(); k++;
    end
    chk("t3_ack_seen", 32'(mem_ack), 32'd1);
    chk("t3_hold_ack", 32'(mem_addr), 32'd0);
    tick();
    tick();
    chk("t3_req20", 32'(mem_req), 32'd1);
    chk("t3_addr20", 32'(mem_addr), 32'd20);
    inst_ready = 1'b1;
    k = 0;
    while (!inst_valid && k < 12) begin tick(); k++; end
    chk("t3_first_pc", 32'(inst_pc), 32'd20);
    repeat (6) tick();

    // redirect coinciding with the ack of address 5
    set_delay(0, 0);
    do_reset();
    k = 0;
    while (!(mem_req && mem_ack && mem_addr == 5'd5) && k < 20) begin
      tick(); k++;
    end
    chk("t4_at5", 32'(mem_addr), 32'd5);
    redirect = 1'b1; redirect_pc = 5'd9;
    tick();
    redirect = 1'b0;
    chk("t4_req", 32'(mem_req), 32'd1);
    chk("t4_addr9", 32'(mem_addr), 32'd9);
    chk("t4_flush", 32'(inst_valid), 32'd0);
    seen5 = 0;
    repeat (8) begin
      if (inst_valid && inst_pc == 5'd5) seen5 = 1;
      tick();
    end
    chk("t4_no5", 32'(seen5), 32'd0);

    // PC wrap 30,31,0,1
    redirect = 1'b1; redirect_pc = 5'd30;
    tick();
    redirect = 1'b0;
    k = 0; idx = 0;
    while (idx < 4 && k < 20) begin
      if (inst_valid) begin
        chk("t5_wrap", 32'(inst_pc), 32'(want[idx]));
        idx++;
      end
      tick(); k++;
    end
    chk("t5_count", 32'(idx), 32'd4);

    // halt with two entries queued
    inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 5'd10;
    tick();
    redirect = 1'b0;
    k = 0;
    while (fifo_count != 3'd1 && k < 10) begin tick(); k++; end
    halt = 1'b1;
    tick();
    chk("t6_cnt2", 32'(fifo_count), 32'd2);
    repeat (4) begin
      tick();
      chk("t6_noreq", 32'(mem_req), 32'd0);
      chk("t6_keep", 32'(fifo_count), 32'd2);
    end
    inst_ready = 1'b1;
    tick();
    tick();
    chk("t6_empty", 32'(fifo_count), 32'd0);
    chk("t6_noreq2", 32'(mem_req), 32'd0);
    halt = 1'b0;
    k = 0;
    while (!mem_req && k < 6) begin tick(); k++; end
    chk("t6_resume", 32'(mem_addr), 32'd12);
    repeat (4) tick();

    // random traffic against the stream model
    set_delay(0, 3);
    for (int c = 0; c < 1500; c++) begin
      inst_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) halt = ~halt;
      if ($urandom_range(19, 0) == 0) begin
        redirect = 1'b1;
        redirect_pc = 5'($urandom);
      end else begin
        redirect = 1'b0;
      end
      tick();
    end
    redirect = 1'b0;
    halt = 1'b0;
    inst_ready = 1'b1;
    n = 0;
    repeat (30) begin
      if (inst_valid) n++;
      tick();
    end
    chk("live", 32'(n > 0), 32'd1);

    // reset in the middle of a request
    k = 0;
    while (!mem_req && k < 10) begin tick(); k++; end
    chk("t8_busy", 32'(mem_req), 32'd1);
    do_reset();
    tick();
    chk("t8_req", 32'(mem_req), 32'd1);
    chk("t8_addr", 32'(mem_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
